// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle for the multi-cycle ALU
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] operator_1;
  logic [WIDTH-1:0] operator_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] answer;
  logic             err;
  logic             busy;

  modport master (
    output flush, in_valid, opcode, operator_1, operator_2, out_ready,
    input  in_ready, out_valid, answer, err, busy
  );

  modport slave (
    input  flush, in_valid, opcode, operator_1, operator_2, out_ready,
    output in_ready, out_valid, answer, err, busy
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer ALU (shift-add MUL, restoring DIV under ALU_MC_DIV_EN)
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic    clk,
  input logic    rst,
  alu_mc_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_MUL    = 5'h02;
  localparam logic [4:0] OP_MULH   = 5'h03;
  localparam logic [4:0] OP_MULHSU = 5'h04;
  localparam logic [4:0] OP_MULHU  = 5'h05;
  localparam logic [4:0] OP_DIV    = 5'h06;
  localparam logic [4:0] OP_DIVU   = 5'h07;
  localparam logic [4:0] OP_REM    = 5'h08;
  localparam logic [4:0] OP_REMU   = 5'h09;
  localparam logic [4:0] OP_AND    = 5'h0A;
  localparam logic [4:0] OP_OR     = 5'h0B;
  localparam logic [4:0] OP_XOR    = 5'h0C;
  localparam logic [4:0] OP_NOR    = 5'h0D;
  localparam logic [4:0] OP_SLL    = 5'h0E;
  localparam logic [4:0] OP_SRL    = 5'h0F;
  localparam logic [4:0] OP_SRA    = 5'h10;
  localparam logic [4:0] OP_SLT    = 5'h11;
  localparam logic [4:0] OP_SLTU   = 5'h12;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_err;
  logic [WIDTH-1:0]     r_answer;
  logic [4:0]           r_op;
  logic [SHAMT_W-1:0]   r_cnt;
  // MUL: {partial product high, multiplier}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0]   r_prod;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [WIDTH-1:0]     r_opnd;
  // MUL: product sign; DIV: quotient sign
  logic                 r_neg;
`ifdef ALU_MC_DIV_EN
  logic                 r_rneg;
  logic                 r_div0;
  logic [WIDTH-1:0]     r_a_orig;
`endif

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_illegal;
  logic [WIDTH-1:0]     w_simple;
  logic                 w_a_signed;
  logic                 w_b_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [2*WIDTH-1:0]   w_mul_fin;
  logic [2*WIDTH-1:0]   w_iter_next;
  logic [WIDTH-1:0]     w_calc_res;
  logic                 w_last;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
`endif

  assign w_accept      = bus.in_valid & r_in_ready;
  assign w_last        = (r_cnt == SHAMT_W'(WIDTH - 1));

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.answer    = r_answer;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;

  // Decode the incoming opcode: class, legality and single-cycle result
  always_comb begin
    w_simple   = '0;
    w_illegal  = 1'b0;
    w_is_mul   = 1'b0;
    w_is_div   = 1'b0;
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.opcode)
      OP_ADD:    w_simple = bus.operator_1 + bus.operator_2;
      OP_SUB:    w_simple = bus.operator_1 - bus.operator_2;
      OP_MUL, OP_MULHU: w_is_mul = 1'b1;
      OP_MULH:   begin w_is_mul = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; end
      OP_MULHSU: begin w_is_mul = 1'b1; w_a_signed = 1'b1; end
`ifdef ALU_MC_DIV_EN
      OP_DIV, OP_REM: begin w_is_div = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; end
      OP_DIVU, OP_REMU: w_is_div = 1'b1;
`endif
      OP_AND:    w_simple = bus.operator_1 & bus.operator_2;
      OP_OR:     w_simple = bus.operator_1 | bus.operator_2;
      OP_XOR:    w_simple = bus.operator_1 ^ bus.operator_2;
      OP_NOR:    w_simple = ~(bus.operator_1 | bus.operator_2);
      OP_SLL:    w_simple = bus.operator_1 << bus.operator_2[SHAMT_W-1:0];
      OP_SRL:    w_simple = bus.operator_1 >> bus.operator_2[SHAMT_W-1:0];
      OP_SRA:    w_simple = $signed(bus.operator_1) >>> bus.operator_2[SHAMT_W-1:0];
      OP_SLT:    w_simple = {{(WIDTH-1){1'b0}}, $signed(bus.operator_1) < $signed(bus.operator_2)};
      OP_SLTU:   w_simple = {{(WIDTH-1){1'b0}}, bus.operator_1 < bus.operator_2};
      default:   w_illegal = 1'b1;
    endcase
  end

  // Operand magnitudes for the iterative units
  always_comb begin
    w_a_neg = w_a_signed & bus.operator_1[WIDTH-1];
    w_b_neg = w_b_signed & bus.operator_2[WIDTH-1];
    w_a_mag = w_a_neg ? -bus.operator_1 : bus.operator_1;
    w_b_mag = w_b_neg ? -bus.operator_2 : bus.operator_2;
  end

  // One shift-add step: add multiplicand on multiplier LSB, shift right
  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    w_mul_fin  = r_neg ? -w_mul_next : w_mul_next;
  end

`ifdef ALU_MC_DIV_EN
  // One restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    if (w_div_diff[WIDTH])
      w_div_next = {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
    else
      w_div_next = {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    w_quo = r_div0 ? {WIDTH{1'b1}} : (r_neg ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0]);
    w_rem = r_div0 ? r_a_orig : (r_rneg ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH]);
  end
`endif

  // Select the next iteration state and the final result from the last step
  always_comb begin
    w_iter_next = w_mul_next;
    w_calc_res  = '0;
    case (r_op)
      OP_MUL:                       w_calc_res = w_mul_fin[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_mul_fin[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
      OP_DIV, OP_DIVU: begin w_iter_next = w_div_next; w_calc_res = w_quo; end
      OP_REM, OP_REMU: begin w_iter_next = w_div_next; w_calc_res = w_rem; end
`endif
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs; flush outranks everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_answer    <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_opnd      <= '0;
      r_neg       <= 1'b0;
`ifdef ALU_MC_DIV_EN
      r_rneg      <= 1'b0;
      r_div0      <= 1'b0;
      r_a_orig    <= '0;
`endif
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= bus.opcode;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_neg      <= w_a_neg ^ w_b_neg;
            if (w_is_mul) begin
              r_state <= S_CALC;
              r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd  <= w_a_mag;
            end else if (w_is_div) begin
              r_state <= S_CALC;
              r_prod  <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd  <= w_b_mag;
            end else begin
              r_state     <= S_DONE;
              r_answer    <= w_simple;
              r_err       <= w_illegal;
              r_out_valid <= 1'b1;
            end
`ifdef ALU_MC_DIV_EN
            r_rneg   <= w_a_neg;
            r_div0   <= (bus.operator_2 == '0);
            r_a_orig <= bus.operator_1;
`endif
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + 1'b1;
          r_prod <= w_iter_next;
          if (w_last) begin
            r_state     <= S_DONE;
            r_answer    <= w_calc_res;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized and directed self-checking bench for alu_mc
module tb_alu_mc;
`ifdef ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic e, output int lat);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    e = 1'b0;
    lat = 1;
    case (op)
      5'h00: res = a + b;
      5'h01: res = a - b;
      5'h02: begin sp = sa * sb; res = sp[31:0]; lat = 33; end
      5'h03: begin sp = sa * sb; res = sp[63:32]; lat = 33; end
      5'h04: begin sp = sa * $signed(ub); res = sp[63:32]; lat = 33; end
      5'h05: begin up = ua * ub; res = up[63:32]; lat = 33; end
      5'h06, 5'h07, 5'h08, 5'h09: begin
        if (DIV_EN) begin
          lat = 33;
          if (b == 32'd0) res = (op == 5'h06 || op == 5'h07) ? 32'hFFFF_FFFF : a;
          else if (op == 5'h06) begin sp = sa / sb; res = sp[31:0]; end
          else if (op == 5'h07) begin up = ua / ub; res = up[31:0]; end
          else if (op == 5'h08) begin sp = sa % sb; res = sp[31:0]; end
          else begin up = ua % ub; res = up[31:0]; end
        end else begin
          e = 1'b1;
        end
      end
      5'h0A: res = a & b;
      5'h0B: res = a | b;
      5'h0C: res = a ^ b;
      5'h0D: res = ~(a | b);
      5'h0E: res = a << b[4:0];
      5'h0F: res = a >> b[4:0];
      5'h10: begin sp = sa >>> b[4:0]; res = sp[31:0]; end
      5'h11: res = (sa < sb) ? 32'd1 : 32'd0;
      5'h12: res = (ua < ub) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 7));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation and wait (bounded) for out_valid; consume it if out_ready is high
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic e, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.opcode = op;
    bus.operator_1 = a;
    bus.operator_2 = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = bus.answer;
    e = bus.err;
    if (bus.out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.answer !== 32'd0) $display("FAIL reset_answer got %h want 0", bus.answer); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else n_pass++;
  endtask

  task automatic test_directed();
    logic [4:0]  ops[11] = '{5'h00, 5'h10, 5'h03, 5'h02, 5'h06, 5'h08, 5'h07, 5'h08, 5'h06, 5'h1F, 5'h09};
    logic [31:0] as[11]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h1234, 32'd17};
    logic [31:0] bs[11]  = '{32'd1, 32'd4, 32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h5, 32'd5};
    logic [31:0] want[11] = '{32'h0, 32'hF800_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'd2};
    int          wlat[11] = '{1, 1, 33, 33, 33, 33, 33, 33, 33, 1, 33};
    logic [31:0] res, wres;
    logic e, werr;
    int lat, wl;
    for (int i = 0; i < 11; i++) begin
      wres = want[i];
      wl = wlat[i];
      werr = (ops[i] == 5'h1F);
      if (ops[i] >= 5'h06 && ops[i] <= 5'h09 && !DIV_EN) begin wres = 32'd0; wl = 1; werr = 1'b1; end
      do_op(ops[i], as[i], bs[i], res, e, lat);
      n_checks++; if (res !== wres) $display("FAIL dir%0d_answer op=%h got %h want %h", i, ops[i], res, wres); else n_pass++;
      n_checks++; if (e !== werr) $display("FAIL dir%0d_err op=%h got %b want %b", i, ops[i], e, werr); else n_pass++;
      n_checks++; if (lat !== wl) $display("FAIL dir%0d_latency op=%h got %0d want %0d", i, ops[i], lat, wl); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] a, b, res, wres;
    logic e, werr;
    int lat, wl;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      a = rand_operand();
      b = rand_operand();
      ref_model(op, a, b, wres, werr, wl);
      do_op(op, a, b, res, e, lat);
      n_checks++;
      if (res !== wres || e !== werr || lat !== wl)
        $display("FAIL rand%0d op=%h a=%h b=%h got %h/%b/%0d want %h/%b/%0d", i, op, a, b, res, e, lat, wres, werr, wl);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, wres;
    logic e, werr;
    int lat, wl;
    for (int i = 0; i < 8; i++) begin
      ref_model(5'(i % 2 == 0 ? 5'h05 : 5'h01), 32'(i * 1000 + 7), 32'hFFFF_0000 + 32'(i), wres, werr, wl);
      do_op(5'(i % 2 == 0 ? 5'h05 : 5'h01), 32'(i * 1000 + 7), 32'hFFFF_0000 + 32'(i), res, e, lat);
      n_checks++;
      if (res !== wres || e !== werr || lat !== wl)
        $display("FAIL b2b%0d got %h/%b/%0d want %h/%b/%0d", i, res, e, lat, wres, werr, wl);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic e;
    int lat;
    bus.out_ready = 1'b0;
    do_op(5'h00, 32'h1000_0001, 32'h0000_0FFF, res, e, lat);
    n_checks++; if (res !== 32'h1000_1000) $display("FAIL bp_answer got %h want 10001000", res); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      bus.opcode = 5'h01;
      bus.operator_1 = 32'($urandom);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.answer !== 32'h1000_1000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got ans=%h ov=%b ir=%b want 10001000/1/0", c, bus.answer, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen;
    bus.opcode = 5'h02;
    bus.operator_1 = 32'd123;
    bus.operator_2 = 32'd456;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL mul_busy got busy=%b ir=%b want 1/0", bus.busy, bus.in_ready); else n_pass++;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL flush_idle got ir=%b ov=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_result got out_valid=1 want 0"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic e;
    int lat;
    bus.opcode = DIV_EN ? 5'h06 : 5'h03;
    bus.operator_1 = 32'hFFFF_FFF9;
    bus.operator_2 = 32'd2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.answer !== 32'd0 || bus.err !== 1'b0)
      $display("FAIL async_reset got ir=%b ov=%b busy=%b ans=%h err=%b want 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.answer, bus.err);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(5'h0C, 32'hF0F0_F0F0, 32'hFFFF_0000, res, e, lat);
    n_checks++; if (res !== 32'h0F0F_F0F0 || lat !== 1) $display("FAIL post_reset_op got %h/%0d want 0f0ff0f0/1", res, lat); else n_pass++;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.opcode = '0;
    bus.operator_1 = '0;
    bus.operator_2 = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
